// File: rtl/decode_pkg.sv
// Shared opcode constants, immediate-format enum and decoded-entry layout for the
// RV64I decode stage.
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        IMM_U    = 3'b000,
        IMM_J    = 3'b001,
        IMM_I    = 3'b010,
        IMM_B    = 3'b011,
        IMM_S    = 3'b100,
        IMM_NONE = 3'b111
    } imm_type_e;

    typedef struct packed {
        logic [63:0] imm;
        imm_type_e   imm_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  opcode;
        logic        illegal;
    } decoded_t;

    // Unknown opcodes fall into IMM_NONE; is_known distinguishes them from R-type.
    function automatic imm_type_e classify(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC:                      classify = IMM_U;
            OP_JAL:                                classify = IMM_J;
            OP_JALR, OP_LOAD, OP_IMM, OP_IMM32,
            OP_FENCE, OP_SYSTEM:                   classify = IMM_I;
            OP_BRANCH:                             classify = IMM_B;
            OP_STORE:                              classify = IMM_S;
            default:                               classify = IMM_NONE;
        endcase
    endfunction

    function automatic logic is_known(input logic [6:0] op);
        is_known = (classify(op) != IMM_NONE) || (op == OP_REG) || (op == OP_REG32);
    endfunction

endpackage

// File: rtl/decode_imm.sv
// Combinational opcode classifier and immediate former.
// DECODE_ILLEGAL_CHECK_EN: when defined, flags unrecognised encodings as illegal.
module decode_imm (
    input  logic                  [31:0] inst,
    output decode_pkg::imm_type_e        imm_type,
    output logic                  [63:0] imm,
    output logic                         illegal
);
    import decode_pkg::*;

    imm_type_e fmt;
    logic      bad;

    always_comb begin
        fmt = classify(inst[6:0]);
        case (fmt)
            IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J:   imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
            IMM_B:   imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            default: imm = '0;
        endcase
        imm_type = fmt;

`ifdef DECODE_ILLEGAL_CHECK_EN
        bad = (inst[1:0] != 2'b11) || !is_known(inst[6:0]);
`else
        bad = 1'b0;
`endif

        // An illegal encoding carries no meaningful immediate.
        illegal = bad;
        if (bad) begin
            imm_type = IMM_NONE;
            imm      = '0;
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// RV64I decode stage: decodes on entry and buffers decoded entries in a
// 2-entry skid FIFO. Optional illegal checking via DECODE_ILLEGAL_CHECK_EN.
module decode_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     in_inst,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_opcode,
    output logic            out_illegal
);
    import decode_pkg::*;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e    state;
    logic      wr_ptr;
    logic      rd_ptr;
    logic      push;
    logic      pop;
    decoded_t  dec_in;
    decoded_t  head;
    decoded_t  mem [2];
    imm_type_e dec_type;
    logic [63:0] dec_imm;
    logic      dec_illegal;

    decode_imm u_imm (
        .inst     (in_inst),
        .imm_type (dec_type),
        .imm      (dec_imm),
        .illegal  (dec_illegal)
    );

    always_comb begin
        dec_in.imm      = dec_imm;
        dec_in.imm_type = dec_type;
        dec_in.rd       = in_inst[11:7];
        dec_in.rs1      = in_inst[19:15];
        dec_in.rs2      = in_inst[24:20];
        dec_in.funct3   = in_inst[14:12];
        dec_in.opcode   = in_inst[6:0];
        dec_in.illegal  = dec_illegal;
    end

    // A flushing cycle never stores the instruction presented alongside it.
    assign push      = in_valid && in_ready && !flush;
    assign out_valid = (state != EMPTY);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case (state)
                EMPTY: begin
                    if (push) state <= ONE;
                end
                ONE: begin
                    if (push && !pop) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop && !push) begin
                        state    <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= dec_in;
    end

    // Data outputs read as zero whenever nothing is buffered.
    always_comb begin
        head         = mem[rd_ptr];
        out_imm      = '0;
        out_imm_type = '0;
        out_rd       = '0;
        out_rs1      = '0;
        out_rs2      = '0;
        out_funct3   = '0;
        out_opcode   = '0;
        out_illegal  = 1'b0;
        if (out_valid) begin
            out_imm      = head.imm[XLEN-1:0];
            out_imm_type = head.imm_type;
            out_rd       = head.rd;
            out_rs1      = head.rs1;
            out_rs2      = head.rs2;
            out_funct3   = head.funct3;
            out_opcode   = head.opcode;
            out_illegal  = head.illegal;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: queue-based reference model plus
// hand-computed literal checks. Honours DECODE_ILLEGAL_CHECK_EN when defined.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_imm_type;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_opcode;
    logic        out_illegal;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   m_ready;

    decode_ctrl #(.XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct3   (out_funct3),
        .out_opcode   (out_opcode),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    // Reference decode: immediates built as signed offsets, then widened to 64 bits.
    function automatic exp_t model_decode(input logic [31:0] i);
        exp_t e;
        logic signed [31:0] u;
        logic signed [20:0] j;
        logic signed [12:0] b;
        logic signed [11:0] s;
        longint v;
        bit known;
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.f3  = i[14:12];
        e.op  = i[6:0];
        e.ill = 1'b0;
        known = 1'b1;
        v = 0;
        case (i[6:0])
            7'h37, 7'h17: begin e.typ = 3'd0; u = {i[31:12], 12'h000}; v = u; end
            7'h6F: begin e.typ = 3'd1; j = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = j; end
            7'h67, 7'h03, 7'h13, 7'h1B, 7'h0F, 7'h73: begin
                e.typ = 3'd2; s = i[31:20]; v = s;
            end
            7'h63: begin e.typ = 3'd3; b = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = b; end
            7'h23: begin e.typ = 3'd4; s = {i[31:25], i[11:7]}; v = s; end
            7'h33, 7'h3B: e.typ = 3'd7;
            default: begin e.typ = 3'd7; known = 1'b0; end
        endcase
        e.imm = v;
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (!known || i[1:0] != 2'b11) begin
            e.ill = 1'b1;
            e.typ = 3'd7;
            e.imm = '0;
        end
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] inst, input bit ordy, input bit fl);
        in_valid  = v;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
    endtask

    // Model occupancy as a queue of at most two decoded entries.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && m_ready;
            do_pop  = (q.size() != 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model_decode(in_inst));
            m_ready = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_t e;
            e = '{default: '0};
            if (q.size() != 0) e = q[0];
            checkOutput("in_ready", 64'(in_ready), 64'(m_ready));
            checkOutput("out_valid", 64'(out_valid), 64'(q.size() != 0));
            checkOutput("imm", out_imm, e.imm);
            checkOutput("imm_type", 64'(out_imm_type), 64'(e.typ));
            checkOutput("rd", 64'(out_rd), 64'(e.rd));
            checkOutput("rs1", 64'(out_rs1), 64'(e.rs1));
            checkOutput("rs2", 64'(out_rs2), 64'(e.rs2));
            checkOutput("funct3", 64'(out_funct3), 64'(e.f3));
            checkOutput("opcode", 64'(out_opcode), 64'(e.op));
            checkOutput("illegal", 64'(out_illegal), 64'(e.ill));
        end
    end

    localparam logic [31:0] I_A = 32'h00500113;   // addi x2,x0,5
    localparam logic [31:0] I_B = 32'h00A00193;   // addi x3,x0,10
    localparam logic [31:0] I_C = 32'h00F00213;   // addi x4,x0,15

    logic [31:0] tbl [5];
    exp_t pin;

    initial begin
        tbl[0] = 32'h0020A023;   // sw x2,0(x1)
        tbl[1] = 32'h002081B3;   // add x3,x1,x2
        tbl[2] = 32'h008000EF;   // jal x1,8
        tbl[3] = 32'h00001097;   // auipc x1,1
        tbl[4] = 32'hFFC10283;   // lb x5,-4(x2)

        pin = model_decode(32'hFFF00093);
        checkOutput("model_addi_imm", pin.imm, 64'hFFFFFFFFFFFFFFFF);
        pin = model_decode(32'h008000EF);
        checkOutput("model_jal_imm", pin.imm, 64'h0000000000000008);
        pin = model_decode(32'h0020A023);
        checkOutput("model_sw_type", 64'(pin.typ), 64'd4);

        rst_n = 1'b0;
        in_valid = 1'b0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_imm", out_imm, 64'd0);
        checkOutput("rst_illegal", 64'(out_illegal), 64'd0);
        rst_n = 1'b1;

        applyStimulus(1, 32'hFFF00093, 1, 0);
        checkOutput("addi_valid", 64'(out_valid), 64'd1);
        checkOutput("addi_type", 64'(out_imm_type), 64'd2);
        checkOutput("addi_imm", out_imm, 64'hFFFFFFFFFFFFFFFF);
        checkOutput("addi_rd", 64'(out_rd), 64'd1);
        applyStimulus(1, 32'h123452B7, 1, 0);
        checkOutput("lui_type", 64'(out_imm_type), 64'd0);
        checkOutput("lui_imm", out_imm, 64'h0000000012345000);
        checkOutput("lui_rd", 64'(out_rd), 64'd5);
        applyStimulus(1, 32'hFE000EE3, 1, 0);
        checkOutput("beq_type", 64'(out_imm_type), 64'd3);
        checkOutput("beq_imm", out_imm, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus(0, '0, 1, 0);
        checkOutput("drain_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_imm", out_imm, 64'd0);

        $display("[TB] back-pressure with three back-to-back instructions");
        applyStimulus(1, I_A, 0, 0);
        applyStimulus(1, I_B, 0, 0);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1, I_C, 0, 0);
        checkOutput("stall_head_rd", 64'(out_rd), 64'd2);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("drain1_rd", 64'(out_rd), 64'd3);
        applyStimulus(0, '0, 1, 0);
        checkOutput("drain2_valid", 64'(out_valid), 64'd0);

        $display("[TB] simultaneous push/pop in ONE");
        applyStimulus(1, I_A, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, tbl[i % 5], 1, 0);
            checkOutput("one_valid", 64'(out_valid), 64'd1);
            checkOutput("one_in_ready", 64'(in_ready), 64'd1);
        end
        applyStimulus(0, '0, 1, 0);
        checkOutput("one_drain_valid", 64'(out_valid), 64'd0);

        $display("[TB] flush while full");
        applyStimulus(1, I_A, 0, 0);
        applyStimulus(1, I_B, 0, 0);
        applyStimulus(1, I_C, 0, 1);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("flush_not_stored", 64'(out_valid), 64'd0);

        $display("[TB] all-zero instruction");
        applyStimulus(1, 32'h00000000, 0, 0);
        checkOutput("zero_valid", 64'(out_valid), 64'd1);
        checkOutput("zero_type", 64'(out_imm_type), 64'd7);
        checkOutput("zero_imm", out_imm, 64'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        checkOutput("zero_illegal", 64'(out_illegal), 64'd1);
`else
        checkOutput("zero_illegal", 64'(out_illegal), 64'd0);
`endif
        applyStimulus(0, '0, 1, 0);

        $display("[TB] reset during stall");
        applyStimulus(1, I_A, 0, 0);
        applyStimulus(1, I_B, 0, 0);
        rst_n = 1'b0;
        applyStimulus(1, I_C, 0, 1);
        rst_n = 1'b1;
        checkOutput("rst_stall_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_stall_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("rst_stall_empty", 64'(out_valid), 64'd0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning immediate/result width (only 64 supported).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port flush  input  1  discard all buffered instructions.
REQ-005 SHALL have port in_valid  input  1  inst is valid.
REQ-006 SHALL have port in_inst  input  32  raw RV64I instruction.
REQ-007 SHALL have port in_ready  output  1  buffer can accept.
REQ-008 SHALL have port out_valid  output  1  decoded entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts.
REQ-010 SHALL have port out_imm  output  64  sign-extended immediate.
REQ-011 SHALL have port out_imm_type  output  3  immediate format code.
REQ-012 SHALL have port out_rd, out_rs1, out_rs2  output  5 each  register fields inst[11:7], [19:15], [24:20].
REQ-013 SHALL have port out_funct3  output  3  inst[14:12].
REQ-014 SHALL have port out_opcode  output  7  inst[6:0].
REQ-015 SHALL have port out_illegal  output  1  unrecognised encoding.

Function
REQ-016 SHALL map opcode to format: 0110111/0010111 -> U (000); 1101111 -> J (001); 1100111/0000011/0010011/0011011/0001111/1110011 -> I (010); 1100011 -> B (011); 0100011 -> S (100); 0110011/0111011 -> NONE (111).
REQ-017 SHALL form immediate: U {32{i31},i[31:12],12'b0}; J {44{i31},i[19:12],i20,i[30:21],0}; I {52{i31},i[31:20]}; B {52{i31},i7,i[30:25],i[11:8],0}; S {52{i31},i[31:25],i[11:7]}; NONE 0.
REQ-018 SHALL decode combinationally on input and store decoded fields, never raw inst, in a 2-entry FIFO skid buffer.
REQ-019 SHALL track occupancy with FSM EMPTY/ONE/TWO: push only -> +1, pop only -> -1, push and pop together -> unchanged.
REQ-020 SHALL register in_ready: 1 in EMPTY/ONE, 0 in TWO; push = in_valid && in_ready.
REQ-021 SHALL assert out_valid whenever state != EMPTY; pop = out_valid && out_ready; outputs always show the head entry.
REQ-022 SHALL give 1-cycle latency: inst accepted at edge N is on outputs after edge N with out_valid=1.
REQ-023 SHALL preserve order; wrap 1-bit read/write pointers.
REQ-024 SHALL hold head outputs stable while out_valid && !out_ready.
REQ-025 SHALL, on flush, go to EMPTY next edge, ignore same-cycle push, and set in_ready=1.
REQ-026 SHALL drive out_imm/out_imm_type/fields to 0 when out_valid=0.

Reset
REQ-027 SHALL on rst_n=0 at clk edge set state EMPTY, pointers 0, in_ready=1, out_valid=0, all data outputs 0, out_illegal=0.
REQ-028 SHALL give reset priority over flush and push; reset mid-stall drops buffered entries.

Configuration
REQ-029 SHALL with DECODE_ILLEGAL_CHECK_EN defined flag illegal when inst[1:0]!=11 or opcode not in REQ-016, forcing out_imm_type=111 and out_imm=0.
REQ-030 SHALL without DECODE_ILLEGAL_CHECK_EN tie out_illegal to 0 and decode unknown opcodes as NONE; the port remains.

Structure
REQ-031 SHALL place opcode localparams, imm-type enum (IMM_U..IMM_NONE), and decoded-entry struct in package decode_pkg.
REQ-032 SHALL instantiate one sub-module decode_imm (opcode classifier + immediate former, combinational); FIFO/FSM in decode_ctrl.

Verification
REQ-033 SHALL check 0xFFF00093 (addi x1,x0,-1) -> type 010, imm 0xFFFFFFFFFFFFFFFF, rd=1, next cycle out_valid.
REQ-034 SHALL check 0x123452B7 (lui x5) -> type 000, imm 0x0000000012345000; 0xFE000EE3 (beq -4) -> type 011, imm 0xFFFFFFFFFFFFFFFC.
REQ-035 SHALL check out_ready=0, three back-to-back valid insts -> first two accepted, in_ready=0 from the third, release -> in-order drain.
REQ-036 SHALL check simultaneous push/pop in ONE for 10 cycles -> state stays ONE, no loss or duplication.
REQ-037 SHALL check flush while TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed inst not stored.
REQ-038 SHALL check 0x00000000 with macro -> out_illegal=1, type 111, imm 0; without macro -> out_illegal=0.
